// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multicycle control FSM
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;

    localparam logic [1:0] SRCB_RD2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] IMM_DP  = 2'd0;
    localparam logic [1:0] IMM_MEM = 2'd1;
    localparam logic [1:0] IMM_BR  = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_RDATA  = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    // CMP runs as a subtract; any cmd without a dedicated op falls back to ADD
    function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - ARM-style condition field evaluation against NZCV
module cond_unit
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle datapath control FSM with NZCV register
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [3:0]  alu_flags,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        adr_src,
    output logic        mem_req,
    output logic        mem_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic [3:0]  flags,
    output logic        illegal,
    output logic        bus_error
);
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_t        state, state_next;
    logic [CW-1:0] count;
    logic          cond_pass, wait_state, timeout, flag_we;

    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic       i_bit, s_bit;
    assign cond  = instruction[31:28];
    assign op    = instruction[27:26];
    assign i_bit = instruction[25];
    assign cmd   = instruction[24:21];
    assign s_bit = instruction[20];

    logic unused_bits;
    assign unused_bits = ^instruction[19:0];

    cond_unit u_cond (
        .cond      (cond),
        .flags     (flags),
        .cond_pass (cond_pass)
    );

    assign wait_state = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
    assign timeout    = (MEM_TIMEOUT != 0) && wait_state && !mem_ready
                        && (32'(count) == 32'(MEM_TIMEOUT - 1));
    assign flag_we    = (state == EXECUTE) && (s_bit || cmd == CMD_CMP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            flags <= 4'b0000;
            count <= '0;
        end else begin
            state <= state_next;
            if (flag_we)
                flags <= alu_flags;
            // restart the wait count whenever a wait state is (re)entered
            if (!wait_state || state_next != state || timeout)
                count <= '0;
            else if (!mem_ready)
                count <= count + 1'b1;
        end
    end

    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_RD2;
        imm_src     = IMM_DP;
        result_src  = RES_ALUOUT;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        bus_error   = 1'b0;
        case (state)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = FETCH;
                end else if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (!cond_pass)
                    state_next = FETCH;
                else begin
                    case (op)
                        OP_DP:   state_next = EXECUTE;
                        OP_MEM:  state_next = MEM_ADDR;
                        OP_BR:   state_next = BRANCH;
                        default: begin
                            illegal    = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end
            end
            EXECUTE: begin
                alu_src_b   = i_bit ? SRCB_IMM : SRCB_RD2;
                alu_control = alu_decode(cmd);
                state_next  = (cmd == CMD_CMP) ? FETCH : ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALUOUT;
                state_next = FETCH;
            end
            MEM_ADDR: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_MEM;
                state_next = s_bit ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = FETCH;
                end else if (mem_ready)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_RDATA;
                state_next = FETCH;
            end
            MEM_WRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (timeout) begin
                    bus_error  = 1'b1;
                    state_next = FETCH;
                end else if (mem_ready)
                    state_next = FETCH;
            end
            BRANCH: begin
                alu_src_b  = SRCB_IMM;
                imm_src    = IMM_BR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
        // the FETCH decode stays visible during reset, but nothing may commit
        if (rst) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
            bus_error = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed vector bench for multicycle_control
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    logic        clk, rst, mem_ready;
    logic [31:0] instruction;
    logic [3:0]  alu_flags;
    logic        pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, imm_src, result_src;
    logic [3:0]  alu_control, flags;
    logic        illegal, bus_error;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .alu_flags(alu_flags),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
        .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .result_src(result_src), .alu_control(alu_control),
        .flags(flags), .illegal(illegal), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, ir_write, adr_src, mem_req, mem_write, reg_write, alu_src_a;
        logic [1:0] alu_src_b, imm_src, result_src;
        logic [3:0] alu_control, flags;
        logic       illegal, bus_error;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [3:0]  aflags;
        logic        ready;
        outs_t       exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] I_BEQ  = 32'h0A000002;
    localparam logic [31:0] I_BNE  = 32'h1A000002;
    localparam logic [31:0] I_ADDS = 32'hE2921005;
    localparam logic [31:0] I_CMP  = 32'hE1500000;
    localparam logic [31:0] I_NV   = 32'hFA000002;
    localparam logic [31:0] I_ILL  = 32'hEC000000;
    localparam logic [31:0] I_ORR  = 32'hE1821003;
    localparam logic [31:0] I_LDR  = 32'hE5912004;
    localparam logic [31:0] I_SUBS = 32'hE2521001;
    localparam logic [31:0] I_BGE  = 32'hAA000000;
    localparam logic [31:0] I_BLT  = 32'hBA000000;
    localparam logic [31:0] I_EOR  = 32'hE0221003;
    localparam logic [31:0] I_STR  = 32'hE5812004;

    function automatic outs_t base(input logic [3:0] fl);
        outs_t o = '0;
        o.alu_control = 4'b0100;
        o.flags = fl;
        return o;
    endfunction

    function automatic outs_t f_fetch(input logic rdy, input logic [3:0] fl, input logic berr);
        outs_t o = base(fl);
        o.mem_req = 1; o.alu_src_a = 1; o.alu_src_b = 2; o.result_src = 2;
        o.pc_write = rdy; o.ir_write = rdy; o.bus_error = berr;
        return o;
    endfunction

    function automatic outs_t f_decode(input logic [3:0] fl, input logic ill);
        outs_t o = base(fl);
        o.illegal = ill;
        return o;
    endfunction

    function automatic outs_t f_exec(input logic [1:0] b, input logic [3:0] aluc, input logic [3:0] fl);
        outs_t o = base(fl);
        o.alu_src_b = b; o.alu_control = aluc;
        return o;
    endfunction

    function automatic outs_t f_wb(input logic [1:0] res, input logic [3:0] fl);
        outs_t o = base(fl);
        o.reg_write = 1; o.result_src = res;
        return o;
    endfunction

    function automatic outs_t f_memaddr(input logic [3:0] fl);
        outs_t o = base(fl);
        o.alu_src_b = 1; o.imm_src = 1;
        return o;
    endfunction

    function automatic outs_t f_mem(input logic wr, input logic [3:0] fl, input logic berr);
        outs_t o = base(fl);
        o.mem_req = 1; o.adr_src = 1; o.mem_write = wr; o.bus_error = berr;
        return o;
    endfunction

    function automatic outs_t f_branch(input logic [3:0] fl);
        outs_t o = base(fl);
        o.pc_write = 1; o.alu_src_b = 1; o.imm_src = 2; o.result_src = 2;
        return o;
    endfunction

    task automatic add(input string n, input logic [31:0] i, input logic [3:0] af,
                       input logic r, input outs_t e);
        vec_t v;
        v.name = n; v.instr = i; v.aflags = af; v.ready = r; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input outs_t e);
        outs_t a;
        a.pc_write = pc_write; a.ir_write = ir_write; a.adr_src = adr_src;
        a.mem_req = mem_req; a.mem_write = mem_write; a.reg_write = reg_write;
        a.alu_src_a = alu_src_a; a.alu_src_b = alu_src_b; a.imm_src = imm_src;
        a.result_src = result_src; a.alu_control = alu_control; a.flags = flags;
        a.illegal = illegal; a.bus_error = bus_error;
        n_vec++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (pcw irw adr req wr rw a b imm res alu nzcv ill berr)",
                     n, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v);
        instruction = v.instr;
        alu_flags   = v.aflags;
        mem_ready   = v.ready;
        @(negedge clk);
        check(v.name, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; instruction = 32'h0; alu_flags = 4'h0;

        // conditional fail, then a taken branch after a slow fetch
        add("beq_fetch",  I_BEQ, 0, 1, f_fetch(1, 4'b0000, 0));
        add("beq_fail",   I_BEQ, 0, 1, f_decode(4'b0000, 0));
        add("slow_f0",    I_BNE, 0, 0, f_fetch(0, 4'b0000, 0));
        add("slow_f1",    I_BNE, 0, 0, f_fetch(0, 4'b0000, 0));
        add("bne_fetch",  I_BNE, 0, 1, f_fetch(1, 4'b0000, 0));
        add("bne_dec",    I_BNE, 0, 0, f_decode(4'b0000, 0));
        add("bne_br",     I_BNE, 0, 1, f_branch(4'b0000));
        // ADDS: flags latched in EXECUTE, reg_write only in ALU_WB
        add("adds_fetch", I_ADDS, 4'b0100, 1, f_fetch(1, 4'b0000, 0));
        add("adds_dec",   I_ADDS, 4'b0100, 1, f_decode(4'b0000, 0));
        add("adds_exe",   I_ADDS, 4'b0100, 1, f_exec(1, ALU_ADD, 4'b0000));
        add("adds_wb",    I_ADDS, 4'b0000, 1, f_wb(0, 4'b0100));
        // CMP: three cycles, flags from ALU, no writeback
        add("cmp_fetch",  I_CMP, 4'b0110, 1, f_fetch(1, 4'b0100, 0));
        add("cmp_dec",    I_CMP, 4'b0110, 1, f_decode(4'b0100, 0));
        add("cmp_exe",    I_CMP, 4'b0110, 1, f_exec(0, ALU_SUB, 4'b0100));
        // BEQ now taken with Z=1
        add("beq2_fetch", I_BEQ, 0, 1, f_fetch(1, 4'b0110, 0));
        add("beq2_dec",   I_BEQ, 0, 1, f_decode(4'b0110, 0));
        add("beq2_br",    I_BEQ, 0, 1, f_branch(4'b0110));
        add("nv_fetch",   I_NV, 0, 1, f_fetch(1, 4'b0110, 0));
        add("nv_fail",    I_NV, 0, 1, f_decode(4'b0110, 0));
        add("ill_fetch",  I_ILL, 0, 1, f_fetch(1, 4'b0110, 0));
        add("ill_dec",    I_ILL, 0, 1, f_decode(4'b0110, 1));
        // ORR without S must not touch flags
        add("orr_fetch",  I_ORR, 4'b1001, 1, f_fetch(1, 4'b0110, 0));
        add("orr_dec",    I_ORR, 4'b1001, 1, f_decode(4'b0110, 0));
        add("orr_exe",    I_ORR, 4'b1001, 1, f_exec(0, ALU_ORR, 4'b0110));
        add("orr_wb",     I_ORR, 4'b1001, 1, f_wb(0, 4'b0110));
        // LDR with three not-ready cycles
        add("ldr_fetch",  I_LDR, 4'b1111, 1, f_fetch(1, 4'b0110, 0));
        add("ldr_dec",    I_LDR, 4'b1111, 1, f_decode(4'b0110, 0));
        add("ldr_addr",   I_LDR, 4'b1111, 1, f_memaddr(4'b0110));
        add("ldr_rd0",    I_LDR, 4'b1111, 0, f_mem(0, 4'b0110, 0));
        add("ldr_rd1",    I_LDR, 4'b1111, 0, f_mem(0, 4'b0110, 0));
        add("ldr_rd2",    I_LDR, 4'b1111, 0, f_mem(0, 4'b0110, 0));
        add("ldr_rd3",    I_LDR, 4'b1111, 1, f_mem(0, 4'b0110, 0));
        add("ldr_wb",     I_LDR, 4'b1111, 1, f_wb(1, 4'b0110));
        add("subs_fetch", I_SUBS, 4'b1000, 1, f_fetch(1, 4'b0110, 0));
        add("subs_dec",   I_SUBS, 4'b1000, 1, f_decode(4'b0110, 0));
        add("subs_exe",   I_SUBS, 4'b1000, 1, f_exec(1, ALU_SUB, 4'b0110));
        add("subs_wb",    I_SUBS, 4'b0000, 1, f_wb(0, 4'b1000));
        // N=1 V=0: GE fails, LT taken
        add("bge_fetch",  I_BGE, 0, 1, f_fetch(1, 4'b1000, 0));
        add("bge_fail",   I_BGE, 0, 1, f_decode(4'b1000, 0));
        add("blt_fetch",  I_BLT, 0, 1, f_fetch(1, 4'b1000, 0));
        add("blt_dec",    I_BLT, 0, 1, f_decode(4'b1000, 0));
        add("blt_br",     I_BLT, 0, 1, f_branch(4'b1000));
        add("eor_fetch",  I_EOR, 0, 1, f_fetch(1, 4'b1000, 0));
        add("eor_dec",    I_EOR, 0, 1, f_decode(4'b1000, 0));
        add("eor_exe",    I_EOR, 0, 1, f_exec(0, ALU_ADD, 4'b1000));
        add("eor_wb",     I_EOR, 0, 1, f_wb(0, 4'b1000));
        // STR timeout on the 4th wait cycle, then a FETCH timeout, then a good store
        add("str_fetch",  I_STR, 0, 1, f_fetch(1, 4'b1000, 0));
        add("str_dec",    I_STR, 0, 1, f_decode(4'b1000, 0));
        add("str_addr",   I_STR, 0, 1, f_memaddr(4'b1000));
        for (int k = 0; k < 3; k++)
            add($sformatf("str_wait%0d", k), I_STR, 0, 0, f_mem(1, 4'b1000, 0));
        add("str_tmo",    I_STR, 0, 0, f_mem(1, 4'b1000, 1));
        for (int k = 0; k < 3; k++)
            add($sformatf("fetch_wait%0d", k), I_STR, 0, 0, f_fetch(0, 4'b1000, 0));
        add("fetch_tmo",  I_STR, 0, 0, f_fetch(0, 4'b1000, 1));
        add("str2_fetch", I_STR, 0, 1, f_fetch(1, 4'b1000, 0));
        add("str2_dec",   I_STR, 0, 0, f_decode(4'b1000, 0));
        add("str2_addr",  I_STR, 0, 0, f_memaddr(4'b1000));
        add("str2_wr",    I_STR, 0, 1, f_mem(1, 4'b1000, 0));

        #3;
        check("reset_state", f_fetch(0, 4'b0000, 0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // asynchronous reset in the middle of MEM_READ
        vecs.delete();
        add("rldr_fetch", I_LDR, 0, 1, f_fetch(1, 4'b1000, 0));
        add("rldr_dec",   I_LDR, 0, 1, f_decode(4'b1000, 0));
        add("rldr_addr",  I_LDR, 0, 1, f_memaddr(4'b1000));
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);
        mem_ready = 1'b0;
        @(negedge clk);
        check("rldr_read", f_mem(0, 4'b1000, 0));
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("async_rst", f_fetch(0, 4'b0000, 0));
        @(posedge clk);
        #1;
        check("rst_held", f_fetch(0, 4'b0000, 0));
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", f_fetch(1, 4'b0000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Control FSM for the processor's multicycle datapath, directly upstream of the datapath.
- Consumes the fetched instruction word and the ALU flags.
- Produces every datapath select and enable, plus the memory request/write strobes, with a memory ready handshake.
- Holds the architectural NZCV flag register and evaluates the ARM-style condition field.

Parameters:
- MEM_TIMEOUT, 16, cycles to wait for mem_ready before raising bus_error; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- instruction  in  32  instruction register contents (valid from DECODE onward)
- alu_flags  in  4  {N,Z,C,V} from the ALU, current cycle
- mem_ready  in  1  memory has completed the current access
- pc_write  out  1  PC register enable
- ir_write  out  1  instruction register enable
- adr_src  out  1  memory address: 0=PC, 1=ALU result register
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, qualified by mem_req
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=rd1, 1=PC
- alu_src_b  out  2  0=rd2, 1=extended immediate, 2=constant 4
- imm_src  out  2  0=imm8 data processing, 1=imm12 memory, 2=imm24<<2 branch
- result_src  out  2  0=ALU result register, 1=read data, 2=ALU direct
- alu_control  out  4  ALU operation, package encoding
- flags  out  4  architectural NZCV register
- illegal  out  1  one-cycle pulse on undefined op
- bus_error  out  1  one-cycle pulse on memory timeout

Behaviour:
- Instruction fields: cond[31:28], op[27:26] (00 data processing, 01 memory, 10 branch, 11 illegal), I[25], cmd[24:21], S/L[20].
- cmd codes: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010.
- All outputs are combinational from state and inputs. flags and the timeout counter are registered.
- Reset:
  - state=FETCH, flags=0000, counter=0.
  - Outputs are therefore the FETCH decode: mem_req=1, alu_src_a=1, alu_src_b=2, alu_control=ADD, result_src=2; all enables 0.
- FETCH:
  - Drive mem_req, adr_src=0, and PC+4 through the ALU.
  - Remain while mem_ready=0.
  - In the mem_ready=1 cycle, assert ir_write and pc_write, then go to DECODE.
- DECODE:
  - Evaluate cond against flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 is treated as fail.
  - Fail -> FETCH, no writes.
  - Otherwise: op 00 -> EXECUTE; 01 -> MEM_ADDR; 10 -> BRANCH; 11 -> FETCH with illegal=1.
- EXECUTE:
  - alu_src_a=0; alu_src_b = I ? 1 : 0; imm_src=0; alu_control from cmd.
  - If S=1 (or cmd=CMP), latch alu_flags into flags at this clock edge.
  - cmd=CMP -> FETCH; otherwise -> ALU_WB.
- ALU_WB: reg_write=1, result_src=0 -> FETCH.
- MEM_ADDR: alu_src_a=0, alu_src_b=1, imm_src=1, ADD. Next state: L=1 -> MEM_READ, L=0 -> MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then -> MEM_WB.
- MEM_WB: reg_write=1, result_src=1 -> FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then -> FETCH.
- BRANCH: alu_src_a=0 (datapath supplies R15), alu_src_b=1, imm_src=2, ADD, result_src=2, pc_write=1 -> FETCH.
- Unlisted cmd values decode as ADD.
- Flags update only in EXECUTE. Memory ops and branches never modify flags.
- Timeout:
  - Counter clears on entering any wait state and increments each cycle mem_ready=0.
  - On reaching MEM_TIMEOUT: bus_error pulses for one cycle, state -> FETCH, no writes for that instruction.
- mem_ready outside wait states is ignored.
- rst mid-operation forces FETCH and flags=0000 immediately, independent of clk. No write enable is asserted in the reset cycle.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state_t enum: FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, BRANCH.
  - ALU op codes, op/cmd field constants, cond code constants.
  - Select encodings for alu_src_b, imm_src, result_src.
- One combinational sub-module, cond_unit, maps (cond, flags) -> cond_pass.

Test Plan:
1. Reset: assert rst asynchronously mid-MEM_READ -> state FETCH, flags=0000, mem_req=1, reg_write=0 without a clock edge.
2. ADDS R1,R2,#5 (0xE2921005), mem_ready=1 on first fetch cycle, alu_flags=0100:
   - FETCH(ir_write, pc_write)/DECODE/EXECUTE/ALU_WB sequence.
   - reg_write only in cycle 4; flags=0100 after EXECUTE.
3. Conditional fail: flags Z=0, BEQ (0x0A000002) -> DECODE returns to FETCH; pc_write stays 0 after fetch.
4. LDR (0xE5912004) with mem_ready low for 3 cycles in MEM_READ:
   - mem_req=1 and adr_src=1 held for 4 cycles.
   - MEM_WB asserts reg_write with result_src=1.
5. CMP R0,R0 (0xE1500000) with alu_flags=0110 -> flags=0110, no reg_write, back to FETCH after 3 cycles.
6. MEM_TIMEOUT=4, STR with mem_ready held low -> bus_error pulses once on the 4th wait cycle, then FETCH. Also: op=11 word -> illegal pulses in DECODE.
